// File: rtl/dds_phase_loader.sv
// DDS phase loader: turns an encoder frequency index into a phase increment with a
// serial shift-add multiplier and swaps it into the accumulator at the phase wrap point.
module dds_phase_loader #(
   parameter int ADDR_W = 11,
   parameter int K_W    = 16,
   parameter int STEP_K = 1790,
   parameter int ACC_W  = 32,
   parameter int LUT_W  = 10
) (
   input  logic              Fg_clk,
   input  logic              Resetn,
   input  logic [ADDR_W-1:0] address,
   input  logic              FreqChng,
   output logic [LUT_W-1:0]  phase,
   output logic [ACC_W-1:0]  inc_cur,
   output logic              busy,
   output logic              upd
);

   localparam int P_W   = ADDR_W + K_W;
   localparam int CNT_W = $clog2(ADDR_W + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] ARM  = 2'd2;

   logic [ACC_W-1:0]  phase_acc_r;
   logic [ACC_W-1:0]  inc_cur_r;
   logic [ACC_W-1:0]  inc_next_r;
   logic [1:0]        state_r;
   logic              busy_r;
   logic              upd_r;
   logic [ADDR_W-1:0] a_r;
   logic [P_W-1:0]    mcand_r;
   logic [P_W-1:0]    prod_r;
   logic [CNT_W-1:0]  cnt_r;

   logic [ACC_W:0]    sum_s;
   logic              wrap_s;
   logic [P_W-1:0]    prod_add_s;
   logic              last_s;
   logic              apply_s;
   logic              load_s;
   logic [1:0]        state_nx_s;

   assign sum_s      = {1'b0, phase_acc_r} + {1'b0, inc_cur_r};
   assign wrap_s     = sum_s[ACC_W];
   assign prod_add_s = a_r[0] ? (prod_r + mcand_r) : prod_r;
   assign last_s     = (cnt_r == CNT_W'(ADDR_W - 1));
   // A stopped accumulator never wraps, so a zero increment is replaced at once.
   assign apply_s    = (state_r == ARM) && (wrap_s || (inc_cur_r == {ACC_W{1'b0}}));

   // Next-state decode; a strobe in any state (re)starts the multiply.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (FreqChng) begin
               state_nx_s = MUL;
               load_s     = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         MUL: begin
            if (FreqChng) begin
               state_nx_s = MUL;
               load_s     = 1'b1;
            end else if (last_s) begin
               state_nx_s = ARM;
            end else begin
               state_nx_s = MUL;
            end
         end
         ARM: begin
            if (FreqChng) begin
               state_nx_s = MUL;
               load_s     = 1'b1;
            end else if (apply_s) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = ARM;
            end
         end
         default: begin
            state_nx_s = IDLE;
            load_s     = 1'b0;
         end
      endcase
   end

   // State, phase accumulator and output registers.
   always_ff @(posedge Fg_clk or negedge Resetn) begin
      if (!Resetn) begin
         state_r     <= IDLE;
         phase_acc_r <= {ACC_W{1'b0}};
         inc_cur_r   <= {ACC_W{1'b0}};
         busy_r      <= 1'b0;
         upd_r       <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         phase_acc_r <= sum_s[ACC_W-1:0];
         busy_r      <= (state_nx_s != IDLE);
         upd_r       <= apply_s;
         if (apply_s) begin
            inc_cur_r <= inc_next_r;
         end else begin
            inc_cur_r <= inc_cur_r;
         end
      end
   end

   // Serial shift-add multiplier: one multiplier bit per MUL cycle.
   always_ff @(posedge Fg_clk or negedge Resetn) begin
      if (!Resetn) begin
         a_r        <= {ADDR_W{1'b0}};
         mcand_r    <= {P_W{1'b0}};
         prod_r     <= {P_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         inc_next_r <= {ACC_W{1'b0}};
      end else begin
         if (load_s) begin
            a_r     <= address;
            mcand_r <= P_W'(STEP_K);
            prod_r  <= {P_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
         end else if (state_r == MUL) begin
            a_r     <= a_r >> 1;
            mcand_r <= mcand_r << 1;
            prod_r  <= prod_add_s;
            cnt_r   <= cnt_r + CNT_W'(1);
         end else begin
            a_r     <= a_r;
            mcand_r <= mcand_r;
            prod_r  <= prod_r;
            cnt_r   <= cnt_r;
         end
         if ((state_r == MUL) && !FreqChng && last_s) begin
            inc_next_r <= ACC_W'(prod_add_s);
         end else begin
            inc_next_r <= inc_next_r;
         end
      end
   end

   assign phase   = phase_acc_r[ACC_W-1 -: LUT_W];
   assign inc_cur = inc_cur_r;
   assign busy    = busy_r;
   assign upd     = upd_r;

endmodule

// File: tb/tb_dds_phase_loader.sv
// Directed testbench for dds_phase_loader: load latency, wrap-aligned apply,
// supersede, zero increment and asynchronous reset.
module tb_dds_phase_loader;

   logic        Fg_clk;
   logic        Resetn;
   logic [10:0] address;
   logic        FreqChng;
   logic [9:0]  phase;
   logic [31:0] inc_cur;
   logic        busy;
   logic        upd;

   int          tests;
   int          fails;
   logic [31:0] exp_acc;
   logic [31:0] exp_inc;

   dds_phase_loader dut (
      .Fg_clk   (Fg_clk),
      .Resetn   (Resetn),
      .address  (address),
      .FreqChng (FreqChng),
      .phase    (phase),
      .inc_cur  (inc_cur),
      .busy     (busy),
      .upd      (upd)
   );

   initial Fg_clk = 1'b0;
   always #5 Fg_clk = ~Fg_clk;

   function automatic logic carry(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32];
   endfunction

   // one clock edge; the expected accumulator advances by the increment in force before it
   task automatic step();
      @(posedge Fg_clk);
      #1;
      exp_acc = exp_acc + exp_inc;
   endtask

   task automatic strobe(input logic [10:0] a);
      address  = a;
      FreqChng = 1'b1;
      step();
      FreqChng = 1'b0;
   endtask

   // edges after the strobe: apply expected at the first edge >= min_n that wraps (or at once if stopped)
   task automatic wait_apply(input logic [31:0] new_inc, input int min_n, input int bound,
                             input logic [31:0] forbid);
      logic c;
      logic exp_apply;
      bit   done;
      done = 1'b0;
      for (int n = 1; n <= bound && !done; n++) begin
         c = carry(exp_acc, exp_inc);
         step();
         exp_apply = (n >= min_n) && (c || (exp_inc == 32'd0));
         tests++;
         if (upd !== exp_apply) begin
            fails++;
            $display("FAIL apply_upd edge %0d: upd=%b expected %b", n, upd, exp_apply);
         end
         tests++;
         if (phase !== exp_acc[31:22]) begin
            fails++;
            $display("FAIL apply_phase edge %0d: phase=%0d expected %0d", n, phase, exp_acc[31:22]);
         end
         tests++;
         if (inc_cur === forbid) begin
            fails++;
            $display("FAIL superseded_value edge %0d: inc_cur=%0d must never appear", n, inc_cur);
         end
         if (exp_apply) begin
            tests++;
            if (inc_cur !== new_inc) begin
               fails++;
               $display("FAIL apply_inc: inc_cur=%0d expected %0d", inc_cur, new_inc);
            end
            exp_inc = new_inc;
            done    = 1'b1;
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL apply_timeout: no apply within %0d edges", bound);
      end
   endtask

   task automatic test_reset();
      tests++;
      if ({phase, inc_cur, busy, upd} !== 44'd0) begin
         fails++;
         $display("FAIL reset_outputs: phase=%0d inc=%0d busy=%b upd=%b expected all 0",
                  phase, inc_cur, busy, upd);
      end
      #13 Resetn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         tests++;
         if ({phase, inc_cur, busy, upd} !== 44'd0) begin
            fails++;
            $display("FAIL idle_after_reset cycle %0d: phase=%0d inc=%0d busy=%b upd=%b expected 0",
                     i, phase, inc_cur, busy, upd);
         end
      end
   endtask

   task automatic test_load_100();
      strobe(11'd100);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_after_e0: busy=%b expected 1", busy);
      end
      wait_apply(32'd179000, 12, 12, 32'hFFFF_FFFF);
      step();
      tests++;
      if (busy !== 1'b0 || upd !== 1'b0) begin
         fails++;
         $display("FAIL after_e13: busy=%b upd=%b expected 0 0", busy, upd);
      end
      for (int i = 0; i < 30; i++) begin
         step();
         tests++;
         if (phase !== exp_acc[31:22] || inc_cur !== 32'd179000) begin
            fails++;
            $display("FAIL run_179000 cycle %0d: phase=%0d inc=%0d expected %0d 179000",
                     i, phase, inc_cur, exp_acc[31:22]);
         end
      end
   endtask

   task automatic test_wrap_1800();
      strobe(11'd1800);
      wait_apply(32'd3222000, 12, 30000, 32'hFFFF_FFFF);
      step();
      tests++;
      if (upd !== 1'b0 || inc_cur !== 32'd3222000 || phase !== exp_acc[31:22]) begin
         fails++;
         $display("FAIL post_wrap_apply: upd=%b inc=%0d phase=%0d expected 0 3222000 %0d",
                  upd, inc_cur, phase, exp_acc[31:22]);
      end
   endtask

   task automatic test_zero_then_one();
      logic [9:0] held;
      strobe(11'd0);
      wait_apply(32'd0, 12, 3000, 32'hFFFF_FFFF);
      held = exp_acc[31:22];
      for (int i = 0; i < 20; i++) begin
         step();
         tests++;
         if (phase !== held || inc_cur !== 32'd0 || upd !== 1'b0) begin
            fails++;
            $display("FAIL frozen cycle %0d: phase=%0d inc=%0d upd=%b expected %0d 0 0",
                     i, phase, inc_cur, upd, held);
         end
      end
      strobe(11'd1);
      wait_apply(32'd1790, 12, 12, 32'hFFFF_FFFF);
   endtask

   task automatic test_reset_mid_arm();
      strobe(11'd7);
      for (int i = 0; i < 13; i++) step();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL pending_in_arm: busy=%b expected 1", busy);
      end
      #2 Resetn = 1'b0;
      #1;
      tests++;
      if ({phase, inc_cur, busy, upd} !== 44'd0) begin
         fails++;
         $display("FAIL async_reset: phase=%0d inc=%0d busy=%b upd=%b expected all 0",
                  phase, inc_cur, busy, upd);
      end
      #2 Resetn = 1'b1;
      exp_acc = 32'd0;
      exp_inc = 32'd0;
      for (int i = 0; i < 30; i++) begin
         step();
         tests++;
         if ({phase, inc_cur, busy, upd} !== 44'd0) begin
            fails++;
            $display("FAIL after_reset_release cycle %0d: phase=%0d inc=%0d busy=%b upd=%b expected 0",
                     i, phase, inc_cur, busy, upd);
         end
      end
   endtask

   task automatic test_supersede();
      strobe(11'd500);
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (busy !== 1'b1 || upd !== 1'b0) begin
            fails++;
            $display("FAIL mid_mul cycle %0d: busy=%b upd=%b expected 1 0", i, busy, upd);
         end
      end
      strobe(11'd20);
      wait_apply(32'd35800, 12, 40, 32'd895000);
      for (int i = 0; i < 30; i++) begin
         step();
         tests++;
         if (upd !== 1'b0 || inc_cur !== 32'd35800 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_upd cycle %0d: upd=%b inc=%0d busy=%b expected 0 35800 0",
                     i, upd, inc_cur, busy);
         end
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      exp_acc  = 32'd0;
      exp_inc  = 32'd0;
      Resetn   = 1'b0;
      FreqChng = 1'b0;
      address  = 11'd0;
      #10;
      test_reset();
      test_load_100();
      test_wrap_1800();
      test_zero_then_one();
      test_reset_mid_arm();
      test_supersede();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dds_phase_loader.md
Name: dds_phase_loader

Overview:
- Sits directly downstream of the rotary encoder front end.
- Consumes the frequency index `address` (0–1800) and the one-cycle `FreqChng` strobe, and converts the index into a DDS phase increment with a serial shift-add multiplier.
- Applies the new increment to the phase accumulator only at the accumulator wrap point, so the frequency changes glitch-free at phase 0.
- Drives the truncated phase to the waveform LUT stage.

Parameters:
- ADDR_W, 11, width of the incoming frequency index.
- K_W, 16, width of the per-step increment constant.
- STEP_K, 1790, phase increment per index unit (≈10 Hz per step at 24 MHz with a 32-bit accumulator).
- ACC_W, 32, phase accumulator width.
- LUT_W, 10, number of phase MSBs forwarded to the waveform LUT.

Ports:
- Fg_clk  in  1  system clock; all state is rising-edge.
- Resetn  in  1  asynchronous active-low reset.
- address  in  ADDR_W  frequency index from the encoder stage; sampled only when FreqChng=1.
- FreqChng  in  1  one-cycle strobe: the new index is valid.
- phase  out  LUT_W  phase_acc[ACC_W-1 -: LUT_W], the LUT address.
- inc_cur  out  ACC_W  increment currently being accumulated.
- busy  out  1  high while in MUL or ARM.
- upd  out  1  one-cycle pulse in the cycle a new increment is applied.

Behaviour:
- Reset: phase_acc=0, inc_cur=0, inc_next=0, state=IDLE, busy=0, upd=0, multiplier registers=0. Output phase is therefore 0.
- Accumulator:
  - Every cycle: phase_acc <= phase_acc + inc_cur, modulo 2^ACC_W.
  - wrap = carry-out of that add.
  - phase is a registered slice of phase_acc.
- FSM, state IDLE:
  - On FreqChng: latch address into a_reg, clear prod, load mcand=STEP_K, set bit counter=0, go to MUL.
- FSM, state MUL (exactly ADDR_W cycles):
  - Each cycle: if a_reg[0], prod += mcand; then a_reg >>= 1, mcand <<= 1, counter++.
  - prod width is ADDR_W+K_W, zero-extended to ACC_W.
  - After the ADDR_W-th cycle: inc_next <= final prod, go to ARM.
- FSM, state ARM:
  - Apply in the first cycle where wrap=1, or immediately (first ARM cycle) if inc_cur==0, because a stopped accumulator never wraps.
  - Apply means: inc_cur <= inc_next, upd=1 for one cycle, go to IDLE.
  - In the apply cycle phase_acc still advances by the old inc_cur. The new increment takes effect from the next cycle.
- Latency: FreqChng sampled at edge E0. MUL runs edges E1..E11 (ADDR_W=11). ARM is entered after E11. Earliest apply is edge E12, with upd and new inc_cur visible after E12.
- FreqChng during MUL or ARM: restart MUL with the new address. Any partial product and any pending inc_next are discarded, and there is no upd for the superseded value.
- FreqChng in the same cycle as an apply in ARM: the apply completes (upd=1, inc_cur updated) and the FSM goes to MUL with the new address, not IDLE.
- address=0 yields inc_next=0. The apply waits for the next wrap, after which the accumulator freezes at its post-wrap value (near 0).
- An apply with inc_next==inc_cur still pulses upd.
- busy = (state != IDLE).
- Undefined state encodings return to IDLE.
- Resetn asserted mid-MUL or mid-ARM: all registers return to reset values asynchronously, and the pending value is lost.
- Max product 1800×1790 = 3,222,000, which fits in 22 bits; no saturation is needed at the default parameters.

Test Plan:
- Reset release, no FreqChng for 100 cycles -> phase=0, inc_cur=0, busy=0, upd never asserted.
- From reset, FreqChng with address=100 at E0 -> busy=1 after E0; upd=1 and inc_cur=179000 after E12; busy=0 after E13; phase_acc then increases by 179000 per cycle.
- With inc_cur=179000 running, FreqChng with address=1800 -> upd asserted only in the cycle whose add carries out of bit 31; inc_cur becomes 3,222,000; phase_acc at that edge equals the old phase_acc + 179000 − 2^32.
- FreqChng address=500 then address=20 six cycles later (mid-MUL) -> single upd, inc_cur=35800; the value 895000 never appears.
- FreqChng address=0 while inc_cur=179000 -> after the next wrap inc_cur=0 and phase_acc holds constant thereafter; a subsequent FreqChng address=1 applies after E12 (immediate, since inc_cur=0), giving inc_cur=1790.
- Resetn pulsed low mid-ARM with inc_next pending -> all outputs 0 immediately; no upd after release until a new FreqChng.
